// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MUL / DIV / MOD unit for the execute stage.
// One shared datapath runs a shift-add multiply or a restoring divide over
// WIDTH cycles, holds the pipeline stalled meanwhile and pulses done once.
module muldiv_sequencer #(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] OP_MUL = EXE_CMD_LEN'(10),
  parameter logic [EXE_CMD_LEN-1:0] OP_DIV = EXE_CMD_LEN'(11),
  parameter logic [EXE_CMD_LEN-1:0] OP_MOD = EXE_CMD_LEN'(12)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXE_CMD_LEN-1:0] exe_cmd,
  input  logic [WIDTH-1:0]       op_a,
  input  logic [WIDTH-1:0]       op_b,
  input  logic                   flush,
  output logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic                   div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [EXE_CMD_LEN-1:0] cmd_q;
  logic [CNT_W-1:0]       cnt;
  // a_q: multiplicand / dividend shift register
  // b_q: multiplier shift register / divisor
  // acc_q: product accumulator / partial remainder
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [WIDTH-1:0]       acc_q;
  logic [WIDTH-1:0]       q_q;
  logic [WIDTH-1:0]       result_q;
  logic                   dbz_pend;
  logic                   dbz_q;

  logic                   accept;
  logic                   is_op;
  logic                   zero_div;
  logic                   last_iter;
  logic [WIDTH-1:0]       mul_acc_nxt;
  logic [WIDTH:0]         trial;
  logic [WIDTH+1:0]       diff;
  logic                   ge;
  logic [WIDTH-1:0]       rem_nxt;
  logic [WIDTH-1:0]       quot_nxt;
  logic [WIDTH-1:0]       sel;
  logic                   unused_diff_bit;

  // Accept decode and one iteration of the shared datapath.
  always_comb begin
    is_op     = (exe_cmd == OP_MUL) || (exe_cmd == OP_DIV) || (exe_cmd == OP_MOD);
    accept    = start && (state == IDLE) && is_op && !flush;
    zero_div  = ((exe_cmd == OP_DIV) || (exe_cmd == OP_MOD)) && (op_b == '0);
    last_iter = (cnt == CNT_W'(WIDTH - 1));

    mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);

    // The trial remainder keeps the bit shifted out of acc_q so divisors
    // above 2^(WIDTH-1) still compare correctly.
    trial    = {acc_q, a_q[WIDTH-1]};
    diff     = {1'b0, trial} - {2'b00, b_q};
    ge       = !diff[WIDTH+1];
    rem_nxt  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_nxt = {q_q[WIDTH-2:0], ge};
    unused_diff_bit = diff[WIDTH];

    sel = (cmd_q == OP_DIV) ? q_q : acc_q;
  end

  // Sequencer state, operand latching and iteration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      result_q <= '0;
      dbz_pend <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q <= exe_cmd;
            a_q   <= op_a;
            b_q   <= op_b;
            cnt   <= '0;
            dbz_q <= 1'b0;
            if (zero_div) begin
              // Zero divisor skips the iterations: quotient all-ones,
              // remainder is the dividend.
              state    <= DONE;
              q_q      <= '1;
              acc_q    <= op_a;
              dbz_pend <= 1'b1;
            end else begin
              state    <= RUN;
              q_q      <= '0;
              acc_q    <= '0;
              dbz_pend <= 1'b0;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            a_q <= a_q << 1;
            if (cmd_q == OP_MUL) begin
              acc_q <= mul_acc_nxt;
              b_q   <= b_q >> 1;
            end else begin
              acc_q <= rem_nxt;
              q_q   <= quot_nxt;
            end
            if (last_iter) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          // The final value is shown combinationally during DONE and
          // captured here so it holds until the next accept.
          if (!flush) begin
            result_q <= sel;
            dbz_q    <= dbz_pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs; result is live during the done cycle, held otherwise.
  always_comb begin
    busy        = (state != IDLE);
    stall       = accept || (state == RUN);
    done        = (state == DONE) && !flush;
    result      = done ? sel : result_q;
    div_by_zero = done ? dbz_pend : dbz_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of muldiv_sequencer
// against a cycle-count behavioural model built from plain arithmetic.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_MOD = 4'd12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    exe_cmd = OP_ADD;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          flush = 1'b0;
  logic          stall, busy, done, div_by_zero;
  logic [W-1:0]  result;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_sequencer #(
    .WIDTH(W), .CNT_W(6), .EXE_CMD_LEN(4),
    .OP_MUL(OP_MUL), .OP_DIV(OP_DIV), .OP_MOD(OP_MOD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .exe_cmd(exe_cmd),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
  endtask

  function automatic bit is_op(input logic [3:0] c);
    return (c == OP_MUL) || (c == OP_DIV) || (c == OP_MOD);
  endfunction

  // Behavioural model: an accepted op completes at a known cycle with a
  // value from plain arithmetic; everything else follows from that window.
  int           cyc = 0;
  bit           m_active = 0;
  int           m_t_done = 0;
  logic [W-1:0] m_pend = '0;
  logic         m_pend_dbz = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic         m_hold_dbz = 1'b0;

  always @(negedge clk) begin
    bit           m_accept;
    bit           e_stall, e_done;
    logic [W-1:0] e_res;
    logic         e_dbz;
    cyc++;
    if (!rst) begin
      m_active   = 0;
      m_hold     = '0;
      m_hold_dbz = 1'b0;
    end
    m_accept = rst && !m_active && start && is_op(exe_cmd) && !flush;
    e_stall  = (!rst && start && is_op(exe_cmd) && !flush) || m_accept ||
               (m_active && cyc != m_t_done);
    e_done   = m_active && (cyc == m_t_done) && !flush;
    e_res    = e_done ? m_pend : m_hold;
    e_dbz    = e_done ? m_pend_dbz : m_hold_dbz;
    chk("stall", W'(stall), W'(e_stall));
    chk("busy", W'(busy), W'(m_active));
    chk("done", W'(done), W'(e_done));
    chk("result", result, e_res);
    chk("div_by_zero", W'(div_by_zero), W'(e_dbz));
    if (rst) begin
      if (m_active) begin
        if (e_done) begin
          m_hold     = m_pend;
          m_hold_dbz = m_pend_dbz;
        end
        if (flush || cyc == m_t_done) m_active = 0;
      end else if (m_accept) begin
        bit z;
        z = (exe_cmd != OP_MUL) && (op_b == '0);
        m_active   = 1;
        m_t_done   = cyc + (z ? 1 : W + 1);
        m_pend_dbz = z;
        m_hold_dbz = 1'b0;
        if (exe_cmd == OP_MUL)      m_pend = op_a * op_b;
        else if (exe_cmd == OP_DIV) m_pend = z ? '1 : op_a / op_b;
        else                        m_pend = z ? op_a : op_a % op_b;
      end
    end
  end

  // Present one instruction, keep it presented while the unit works (as a
  // frozen pipeline would), optionally flush at cycle flush_at after accept.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int flush_at, input bit scramble,
                       output int lat, output logic [W-1:0] res, output logic dbz);
    exe_cmd = c; op_a = a; op_b = b; start = 1'b1; flush = (flush_at == 0);
    lat = -1; res = '0; dbz = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) begin lat = k; res = result; dbz = div_by_zero; end
      @(posedge clk); #1;
      if (lat >= 0 || flush) break;
      flush = (k + 1 == flush_at);
      if (scramble) begin op_a = $urandom; op_b = $urandom; end
    end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_res,
                          input logic e_dbz, input int e_lat);
    int lat; logic [W-1:0] res; logic dbz;
    issue(c, a, b, -1, 1'b1, lat, res, dbz);
    chk({nm, "_lat"}, W'(lat), W'(e_lat));
    chk({nm, "_res"}, res, e_res);
    chk({nm, "_dbz"}, W'(dbz), W'(e_dbz));
    @(negedge clk);
    chk({nm, "_hold"}, result, e_res);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, lat2; logic [W-1:0] res, res2; logic dbz;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_stall", W'(stall), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_result", result, '0);
    chk("rst_dbz", W'(div_by_zero), '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    directed("mul_7x6",   OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33);
    directed("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    directed("mod_100_7", OP_MOD, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    directed("div_by_0",  OP_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    directed("mod_by_0",  OP_MOD, 32'h1234, 32'd0, 32'h1234, 1'b1, 1);
    directed("mul_wrap",  OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33);
    directed("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33);
    directed("div_bigdv", OP_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 1'b0, 33);
    directed("mod_bigdv", OP_MOD, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 33);

    // Flush mid-run: no done, previous result kept.
    issue(OP_MUL, 32'd3, 32'd5, 10, 1'b0, lat, res, dbz);
    chk("flush_no_done", W'(lat), W'(-1));
    @(negedge clk);
    chk("flush_busy", W'(busy), '0);
    chk("flush_stall", W'(stall), '0);
    chk("flush_result", result, 32'h7FFF_FFFE);
    @(posedge clk); #1;

    // Start together with flush while idle: not accepted.
    issue(OP_MUL, 32'd9, 32'd9, 0, 1'b0, lat, res, dbz);
    @(negedge clk);
    chk("idle_flush_busy", W'(busy), '0);
    @(posedge clk); #1;

    // Non-muldiv command is ignored.
    issue(OP_ADD, 32'd1, 32'd2, -1, 1'b0, lat, res, dbz);
    chk("add_ignored", W'(lat), W'(-1));

    // Asynchronous reset in the middle of a run.
    exe_cmd = OP_MUL; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    repeat (6) @(posedge clk);
    #3 start = 1'b0; rst = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    chk("arst_stall", W'(stall), '0);
    chk("arst_done", W'(done), '0);
    chk("arst_result", result, '0);
    chk("arst_dbz", W'(div_by_zero), '0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: second instruction presented right after done.
    issue(OP_DIV, 32'd1000, 32'd10, -1, 1'b0, lat, res, dbz);
    issue(OP_MUL, 32'd123, 32'd456, -1, 1'b0, lat2, res2, dbz);
    chk("b2b_div_lat", W'(lat), W'(33));
    chk("b2b_div_res", res, 32'd100);
    chk("b2b_mul_lat", W'(lat2), W'(33));
    chk("b2b_mul_res", res2, 32'd56088);

    // Randomized traffic; every cycle is checked by the model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] c; logic [W-1:0] a, b; int fa; int sel;
      sel = $urandom_range(0, 6);
      c = (sel == 6) ? OP_ADD : (sel % 3 == 0) ? OP_MUL : (sel % 3 == 1) ? OP_DIV : OP_MOD;
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1000)) : W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 255));
        default: b = W'($urandom);
      endcase
      fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 36) : -1;
      issue(c, a, b, fa, 1'($urandom_range(0, 1)), lat, res, dbz);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution unit and sequencer for the MUL, DIV and MOD operations of the execute stage.
- Accepts an operation from the execute stage and runs an iterative shift-add multiply or a restoring divide over WIDTH cycles on one shared datapath.
- Holds the pipeline stalled while busy, then presents the result for exactly one cycle of done.
- Sits beside the single-cycle ALU; the hazard/stall logic ORs its stall output into the pipeline freeze.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  execute stage holds a valid instruction this cycle.
- exe_cmd  input  EXE_CMD_LEN  execute command. Acted on only for OP_MUL, OP_DIV and OP_MOD (codes from defines.v); all other codes are ignored.
- op_a  input  WIDTH  multiplicand or dividend, unsigned.
- op_b  input  WIDTH  multiplier or divisor, unsigned.
- flush  input  1  synchronous abort (branch taken or pipeline flush).
- stall  output  1  freeze the pipeline stages upstream of execute.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse; result is valid.
- result  output  WIDTH  product low half, quotient, or remainder.
- div_by_zero  output  1  set together with done when a DIV or MOD had op_b equal to 0.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; counter, accumulator, quotient and remainder registers are 0. Outputs: result=0, done=0, div_by_zero=0, busy=0, stall=0.
- Accept condition: `acc = start & (state==IDLE) & exe_cmd in {MUL, DIV, MOD} & !flush`.
- Stall: `stall = acc | (state==RUN)`. It is combinational, so the instruction is frozen in execute from the accept cycle onward. stall is low in the DONE cycle so the pipeline advances and captures the result.
- States: IDLE, RUN, DONE.
- IDLE, on acc:
  - Latch the command, op_a and op_b; clear the counter.
  - If the command is DIV or MOD and op_b==0, go directly to DONE.
  - Otherwise go to RUN.
- RUN: perform one iteration per cycle. After iteration WIDTH (counter==WIDTH-1), go to DONE.
- MUL iteration:
  - If multiplier bit0 is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right.
  - The accumulator is WIDTH bits; higher bits are discarded.
  - result = product mod 2^WIDTH.
- DIV/MOD iteration (restoring):
  - rem = {rem[WIDTH-2:0], dividend MSB}; shift the dividend left.
  - If rem >= divisor: rem -= divisor and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - The compare/subtract is WIDTH+1 bits wide.
  - DIV returns the quotient; MOD returns the remainder.
- DONE: lasts one cycle.
  - done=1; result is valid.
  - div_by_zero=1 only for the zero-divisor case, which returns quotient all-ones and remainder op_a.
  - Return to IDLE next cycle.
- result and div_by_zero hold their values until the next accept; div_by_zero clears on accept.
- Latency: accept at cycle t, done at t+WIDTH+1. For a zero divisor, done at t+1.
- start is ignored while busy. The upstream stages are frozen, so the same instruction is still presented in DONE and must not be re-accepted. A new accept is possible only from IDLE, giving a minimum spacing of WIDTH+2 cycles between accepts.
- flush:
  - In RUN or DONE: return to IDLE next cycle, no done pulse, result unchanged.
  - In IDLE together with start: flush wins and nothing is accepted.
- Reset asserted mid-operation: immediate return to IDLE with all registers cleared.
- Operands are sampled only at accept; later changes on op_a or op_b have no effect.

Test Plan:
- Reset, then MUL op_a=7 op_b=6 (WIDTH=32): stall high for cycles t..t+32; done=1 at t+33 with result=42 and div_by_zero=0; busy low at t+34.
- DIV 100/7: result=14. MOD 100/7: result=2. Both with done at t+33 and result holding after done drops.
- DIV 0x1234/0: done at t+1, result=0xFFFFFFFF, div_by_zero=1. MOD 0x1234/0: result=0x1234, div_by_zero=1.
- MUL 0xFFFFFFFF*2: result=0xFFFFFFFE (wrap). DIV 0xFFFFFFFF/1: result=0xFFFFFFFF.
- Accept MUL, assert flush at t+10: next cycle busy=0 and stall=0; no done pulse; result keeps its previous value. Then start with flush in IDLE: not accepted.
- Start with exe_cmd=OP_ADD: stall, busy and done stay 0. Drop rst mid-RUN: all outputs 0 immediately. Back-to-back DIV then MUL: second accept not before previous done+1, both results correct.
